// File: rtl/vx_csa_accum_seq.sv
// Multi-beat carry-save reduction sequencer: one CSA pass per beat, one CPA at the end.
// Define VX_CSA_ACCUM_SEQ_BEATCNT_EN to add the out_beats beat counter.
module vx_csa_accum_seq #(
   parameter int LANES = 4,
   parameter int W     = 8,
   parameter int ACC_W = 16,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_data,
   input  logic [LANES-1:0]   in_mask,
   input  logic               in_last,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_sum,
   output logic [TAG_W-1:0]   out_tag
`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
   ,
   output logic [15:0]        out_beats
`endif
);

   localparam int NOPS = LANES + 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [ACC_W-1:0] sum_r, carry_r;
   logic [ACC_W-1:0] tree_s, tree_c;
   logic [ACC_W-1:0] ops [NOPS];
   logic [TAG_W-1:0] tag_r;
   logic             beat_acc;
   logic             out_hs;

   assign beat_acc = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   // Lane operands plus the running redundant pair (zeros on a first beat)
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         ops[i] = in_mask[i] ? ACC_W'(in_data[i*W +: W]) : '0;
      end
      ops[LANES]   = (state == ACCUM) ? sum_r   : '0;
      ops[LANES+1] = (state == ACCUM) ? carry_r : '0;
   end

   // 3:2 compressor layers; carry out of the top bit falls off the shift
   always_comb begin
      logic [ACC_W-1:0] s, c, ns, nc;
      s  = ops[0];
      c  = ops[1];
      ns = '0;
      nc = '0;
      for (int i = 2; i < NOPS; i++) begin
         ns = s ^ c ^ ops[i];
         nc = ((s & c) | (s & ops[i]) | (c & ops[i])) << 1;
         s  = ns;
         c  = nc;
      end
      tree_s = s;
      tree_c = c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (beat_acc) state_nx = in_last ? RESOLVE : ACCUM;
         ACCUM:   if (beat_acc && in_last) state_nx = RESOLVE;
         RESOLVE: state_nx = OUTPUT;
         OUTPUT:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE) || (state == ACCUM);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_r     <= '0;
         carry_r   <= '0;
         tag_r     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_tag   <= '0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (beat_acc) begin
                  sum_r   <= tree_s;
                  carry_r <= tree_c;
                  if (state == IDLE) tag_r <= in_tag;
               end
            end
            RESOLVE: begin
               out_sum   <= sum_r + carry_r;
               out_tag   <= tag_r;
               out_valid <= 1'b1;
            end
            OUTPUT: begin
               if (out_hs) begin
                  out_valid <= 1'b0;
                  sum_r     <= '0;
                  carry_r   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          out_beats <= '0;
      else if (out_hs)                       out_beats <= '0;
      else if (beat_acc && out_beats != '1)  out_beats <= out_beats + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vx_csa_accum_seq.sv
// Directed + randomized bench for vx_csa_accum_seq against an arithmetic model.
// Build with VX_CSA_ACCUM_SEQ_BEATCNT_EN to also check out_beats.
module tb_vx_csa_accum_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_mask;
   logic        in_last;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic [3:0]  out_tag;
`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
   logic [15:0] out_beats;
`endif

   int checks = 0;
   int fails  = 0;

   longint msum;
   logic [3:0] mtag;
   int mbeats;
   bit first;

   vx_csa_accum_seq #(
      .LANES(4), .W(8), .ACC_W(16), .TAG_W(4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_last   (in_last),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_tag   (out_tag)
`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
      ,
      .out_beats (out_beats)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      msum   = 0;
      mbeats = 0;
      first  = 1'b1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] m,
                       input logic l, input logic [3:0] t);
      int n;
      in_data  = d;
      in_mask  = m;
      in_last  = l;
      in_tag   = t;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_for_beat", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_mask  = 4'($urandom);
      in_last  = 1'($urandom);
      in_tag   = 4'($urandom);
      if (first) mtag = t;
      first = 1'b0;
      for (int i = 0; i < 4; i++)
         if (m[i]) msum += longint'((d >> (8 * i)) & 32'hFF);
      if (mbeats < 65535) mbeats++;
      if (!l) begin
         chk("accum_in_ready", in_ready, 1);
         chk("accum_out_valid", out_valid, 0);
      end
   endtask

   task automatic finish_red(input string nm, input int hold);
      logic [15:0] exp_sum;
      exp_sum = 16'(msum % 65536);
      chk({nm, "_T1_out_valid"}, out_valid, 0);
      chk({nm, "_T1_in_ready"}, in_ready, 0);
      @(posedge clk); #1;
      chk({nm, "_T2_out_valid"}, out_valid, 1);
      chk({nm, "_T2_in_ready"}, in_ready, 0);
      chk({nm, "_sum"}, out_sum, exp_sum);
      chk({nm, "_tag"}, out_tag, mtag);
`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
      chk({nm, "_beats"}, out_beats, mbeats);
`endif
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({nm, "_hold_valid"}, out_valid, 1);
         chk({nm, "_hold_sum"}, out_sum, exp_sum);
         chk({nm, "_hold_tag"}, out_tag, mtag);
         chk({nm, "_hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_post_out_valid"}, out_valid, 0);
      chk({nm, "_post_in_ready"}, in_ready, 1);
      model_clear();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mask   = '0;
      in_last   = 1'b0;
      in_tag    = '0;
      out_ready = 1'b0;
      model_clear();
      mtag = '0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_tag", out_tag, 0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // single beat {1,2,3,4}, tag 5
      send({8'd4, 8'd3, 8'd2, 8'd1}, 4'hF, 1'b1, 4'd5);
      finish_red("single", 0);

      // three beats of 255s
      send(32'hFFFF_FFFF, 4'hF, 1'b0, 4'd9);
      send(32'hFFFF_FFFF, 4'hF, 1'b0, 4'd1);
      send(32'hFFFF_FFFF, 4'hF, 1'b1, 4'd2);
      finish_red("three", 0);

      // masked beat, two idle cycles, then last
      send({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0101, 1'b0, 4'd3);
      repeat (2) begin
         @(posedge clk); #1;
         chk("gap_in_ready", in_ready, 1);
         chk("gap_out_valid", out_valid, 0);
      end
      send({8'd1, 8'd1, 8'd1, 8'd1}, 4'hF, 1'b1, 4'd7);
      finish_red("mask_gap", 0);

      // 65 beats wrap past 2^16
      for (int b = 0; b < 65; b++)
         send(32'hFFFF_FFFF, 4'hF, 1'(b == 64), 4'd11);
      chk("wrap_model", 32'(msum % 65536), 764);
      finish_red("wrap", 0);

      // backpressure then a residue-free reduction
      send(32'h0102_0304, 4'hF, 1'b1, 4'd12);
      finish_red("bp", 5);
      send({8'd0, 8'd0, 8'd0, 8'd1}, 4'hF, 1'b1, 4'd13);
      finish_red("no_residue", 0);

      // reset abort after two non-last beats
      send(32'h1111_1111, 4'hF, 1'b0, 4'd6);
      send(32'h2222_2222, 4'hF, 1'b0, 4'd6);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_sum", out_sum, 0);
      chk("abort_out_tag", out_tag, 0);
`ifdef VX_CSA_ACCUM_SEQ_BEATCNT_EN
      chk("abort_out_beats", out_beats, 0);
`endif
      model_clear();
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", in_ready, 1);
      send({8'd0, 8'd0, 8'd0, 8'd7}, 4'hF, 1'b1, 4'd4);
      finish_red("after_abort", 0);

      // random reductions
      for (int r = 0; r < 8; r++) begin
         int nb;
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            send($urandom, 4'($urandom), 1'(b == nb - 1), 4'($urandom));
            if (b != nb - 1 && $urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
            end
         end
         finish_red("rand", $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
